fifo_wm: RTL and testbench

//  Parametrised synchronous show-ahead FIFO with programmable almost-full/almost-empty

---
 rtl/fifo_wm_pkg.sv | 16 +
 rtl/fifo_wm_if.sv | 33 +++
 rtl/fifo_wm_ram.sv | 19 +
 rtl/fifo_wm.sv | 75 +++++++
 tb/tb_fifo_wm.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/fifo_wm_pkg.sv
// fifo_wm_pkg: shared helpers for the watermark FIFO.
// Width helpers and a pointer increment that works for any depth, including
// depths that are not a power of two.
package fifo_wm_pkg;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_WIDTH = 8;
  function automatic int cw_of(int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int pw_of(int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  function automatic int unsigned ptr_inc(int unsigned ptr, int unsigned depth);
    return ptr == depth - 1 ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/fifo_wm_if.sv
// fifo_wm_if: push/pop handshake plus status bus of the watermark FIFO.
// Ports: i_* are requests into the FIFO, o_* are data and status out of it.
// master = client driving requests, slave = the FIFO itself.
interface fifo_wm_if import fifo_wm_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CW = cw_of(DEPTH);
  logic             i_flush;
  logic             i_write;
  logic [WIDTH-1:0] i_data;
  logic             i_read;
  logic             i_clear_err;
  logic [WIDTH-1:0] o_data;
  logic             o_full;
  logic             o_empty;
  logic             o_almost_full;
  logic             o_almost_empty;
  logic [CW-1:0]    o_count;
  logic [CW-1:0]    o_peak;
  logic             o_overflow;
  logic             o_underflow;
  modport master (
    output i_flush, i_write, i_data, i_read, i_clear_err,
    input  o_data, o_full, o_empty, o_almost_full, o_almost_empty,
           o_count, o_peak, o_overflow, o_underflow
  );
  modport slave (
    input  i_flush, i_write, i_data, i_read, i_clear_err,
    output o_data, o_full, o_empty, o_almost_full, o_almost_empty,
           o_count, o_peak, o_overflow, o_underflow
  );
endinterface

// File: rtl/fifo_wm_ram.sv
// fifo_wm_ram: WIDTH x DEPTH storage, one synchronous write port, one async read port.
// Ports: clk, we/waddr/wdata (write), raddr -> rdata (combinational read).
module fifo_wm_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int PW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_wm.sv
// fifo_wm: show-ahead synchronous FIFO with watermarks, flush, sticky errors and peak tracking.
// Ports: i_clk, i_reset (sync, active-high), bus (fifo_wm_if.slave) carrying
// push/pop/flush/clear_err requests, head data and all status outputs.
module fifo_wm import fifo_wm_pkg::*; #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 8,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input logic      i_clk,
  input logic      i_reset,
  fifo_wm_if.slave bus
);
  localparam int CW = cw_of(DEPTH);
  localparam int PW = pw_of(DEPTH);
  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_wm: DEPTH must be >= 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("fifo_wm: AFULL_TH must be in 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH >= DEPTH) begin : g_bad_aempty
    $error("fifo_wm: AEMPTY_TH must be in 0..DEPTH-1");
  end
  logic [CW-1:0] count_q, count_d, peak_q, peak_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          pop_ok, push_ok, we;
  always_comb begin
    pop_ok   = bus.i_read & (count_q != '0);
    // a full FIFO still accepts a write when the same cycle pops
    push_ok  = bus.i_write & ((count_q != CW'(DEPTH)) | pop_ok);
    we       = push_ok & ~bus.i_flush;
    rd_ptr_d = bus.i_flush ? '0 : pop_ok ? PW'(ptr_inc(32'(rd_ptr_q), DEPTH)) : rd_ptr_q;
    wr_ptr_d = bus.i_flush ? '0 : push_ok ? PW'(ptr_inc(32'(wr_ptr_q), DEPTH)) : wr_ptr_q;
    count_d  = bus.i_flush ? '0 : count_q + CW'(push_ok) - CW'(pop_ok);
    // a new error in the clearing cycle survives the clear; flush suppresses errors
    ovf_d    = (ovf_q & ~bus.i_clear_err) | (bus.i_write & ~push_ok & ~bus.i_flush);
    unf_d    = (unf_q & ~bus.i_clear_err) | (bus.i_read & ~pop_ok & ~bus.i_flush);
    // clearing restarts the peak from the occupancy being entered, not from zero
    peak_d   = (bus.i_clear_err | (count_d > peak_q)) ? count_d : peak_q;
  end
  always_ff @(posedge i_clk)
    if (i_reset) begin
      count_q  <= '0;
      peak_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      peak_q   <= peak_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  fifo_wm_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PW(PW)) u_ram (
    .clk   (i_clk),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (bus.i_data),
    .raddr (rd_ptr_q),
    .rdata (bus.o_data)
  );
  assign bus.o_count        = count_q;
  assign bus.o_peak         = peak_q;
  assign bus.o_full         = count_q == CW'(DEPTH);
  assign bus.o_empty        = count_q == '0;
  assign bus.o_almost_full  = count_q >= CW'(AFULL_TH);
  assign bus.o_almost_empty = count_q <= CW'(AEMPTY_TH);
  assign bus.o_overflow     = ovf_q;
  assign bus.o_underflow    = unf_q;
endmodule

// File: tb/tb_fifo_wm.sv
// tb_fifo_wm: directed self-checking bench for fifo_wm (DEPTH=5, AFULL_TH=4, AEMPTY_TH=1).
module tb_fifo_wm;
  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  int total = 0;
  int bad = 0;
  fifo_wm_if #(.WIDTH(8), .DEPTH(5)) bus ();
  fifo_wm #(.DEPTH(5), .WIDTH(8), .AFULL_TH(4), .AEMPTY_TH(1)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(logic rst, logic f, logic w, logic [7:0] d, logic r, logic c);
    i_reset = rst;
    bus.i_flush = f;
    bus.i_write = w;
    bus.i_data = d;
    bus.i_read = r;
    bus.i_clear_err = c;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_write = 1'b0;
    bus.i_data = 8'h00;
    bus.i_read = 1'b0;
    bus.i_clear_err = 1'b0;
  endtask
  task automatic chk_reset(string tag);
    chk({tag, "_cnt"}, bus.o_count, 0);
    chk({tag, "_empty"}, bus.o_empty, 1);
    chk({tag, "_full"}, bus.o_full, 0);
    chk({tag, "_ae"}, bus.o_almost_empty, 1);
    chk({tag, "_af"}, bus.o_almost_full, 0);
    chk({tag, "_peak"}, bus.o_peak, 0);
    chk({tag, "_ovf"}, bus.o_overflow, 0);
    chk({tag, "_unf"}, bus.o_underflow, 0);
  endtask
  initial begin
    bus.i_flush = 1'b0;
    bus.i_write = 1'b0;
    bus.i_data = 8'h00;
    bus.i_read = 1'b0;
    bus.i_clear_err = 1'b0;
    // reset
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk_reset("rst");
    // fill 0x11..0x15 with watermark checks
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 8'(8'h11 + i), 0, 0);
      chk("fill_cnt", bus.o_count, i + 1);
      chk("fill_af", bus.o_almost_full, (i + 1) >= 4);
      chk("fill_ae", bus.o_almost_empty, (i + 1) <= 1);
      chk("fill_full", bus.o_full, i == 4);
      chk("fill_head", bus.o_data, 8'h11);
    end
    chk("fill_peak", bus.o_peak, 5);
    // drain in order
    for (int i = 0; i < 5; i++) begin
      chk("drain_data", bus.o_data, 8'h11 + i);
      cyc(0, 0, 0, 0, 1, 0);
      chk("drain_cnt", bus.o_count, 4 - i);
    end
    chk("drain_empty", bus.o_empty, 1);
    chk("drain_peak", bus.o_peak, 5);
    chk("drain_unf", bus.o_underflow, 0);
    // wrap on non-power-of-two depth
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'(8'h20 + r * 3 + i), 0, 0);
      chk("wrap_cnt3", bus.o_count, 3);
      for (int i = 0; i < 3; i++) begin
        chk("wrap_data", bus.o_data, 8'h20 + r * 3 + i);
        cyc(0, 0, 0, 0, 1, 0);
      end
      chk("wrap_cnt0", bus.o_count, 0);
    end
    // full pass-through
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'(8'h31 + i), 0, 0);
    chk("pt_full", bus.o_full, 1);
    cyc(0, 0, 1, 8'hAA, 1, 0);
    chk("pt_cnt", bus.o_count, 5);
    chk("pt_ovf", bus.o_overflow, 0);
    for (int i = 0; i < 4; i++) begin
      chk("pt_data", bus.o_data, 8'h32 + i);
      cyc(0, 0, 0, 0, 1, 0);
    end
    chk("pt_aa", bus.o_data, 8'hAA);
    cyc(0, 0, 0, 0, 1, 0);
    chk("pt_empty", bus.o_empty, 1);
    // read+write on empty
    cyc(0, 0, 1, 8'h55, 1, 0);
    chk("es_cnt", bus.o_count, 1);
    chk("es_data", bus.o_data, 8'h55);
    chk("es_unf", bus.o_underflow, 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("es_cnt0", bus.o_count, 0);
    chk("es_unf_hold", bus.o_underflow, 1);
    // clear restarts peak at current count (0)
    cyc(0, 0, 0, 0, 0, 1);
    chk("clr_unf", bus.o_underflow, 0);
    chk("clr_peak", bus.o_peak, 0);
    // set in the same cycle as clear wins
    cyc(0, 0, 0, 0, 1, 1);
    chk("setclr_unf", bus.o_underflow, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("setclr_unf2", bus.o_underflow, 0);
    // overflow
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'(8'h41 + i), 0, 0);
    cyc(0, 0, 1, 8'hEE, 0, 0);
    chk("ovf_set", bus.o_overflow, 1);
    chk("ovf_cnt", bus.o_count, 5);
    cyc(0, 0, 0, 0, 0, 0);
    chk("ovf_hold", bus.o_overflow, 1);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("ovf_clr", bus.o_overflow, 0);
    chk("ovf_peak", bus.o_peak, 4);
    chk("ovf_head", bus.o_data, 8'h42);
    // flush with simultaneous write at count 3
    cyc(0, 1, 0, 0, 0, 0);
    chk("fl_empty0", bus.o_empty, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'(8'h61 + i), 0, 0);
    chk("fl_cnt3", bus.o_count, 3);
    cyc(0, 1, 1, 8'h77, 0, 0);
    chk("fl_cnt", bus.o_count, 0);
    chk("fl_empty", bus.o_empty, 1);
    chk("fl_ovf", bus.o_overflow, 0);
    chk("fl_peak", bus.o_peak, 4);
    cyc(0, 1, 0, 0, 1, 0);
    chk("fl_unf", bus.o_underflow, 0);
    // after flush the FIFO restarts cleanly
    cyc(0, 0, 1, 8'h88, 0, 0);
    chk("fl_post_data", bus.o_data, 8'h88);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("pre_rst_unf", bus.o_underflow, 1);
    // reset during a push
    cyc(1, 0, 1, 8'h99, 0, 0);
    chk_reset("rst2");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
